aes_rcon_sbox: RTL and testbench

AES-128 key-schedule primitive block: a round-constant (Rcon) generator sequenced by the key-load strobe, plus a combinational forward AES S-box lookup. The key expander uses it once per round. It takes the Rcon word for each expansion step and substitutes bytes of the rotated last key word through the S-box. The block holds no key state; it only produces constants and substitutions.

---
 rtl/aes_rcon_sbox_pkg.sv | 47 ++++
 rtl/aes_rcon_sbox_if.sv | 33 +++
 rtl/aes_rcon_sbox_sbox.sv | 17 +
 rtl/aes_rcon_sbox.sv | 51 +++++
 tb/tb_aes_rcon_sbox.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/aes_rcon_sbox_pkg.sv
// ---------------------------------------------------------------------------
// aes_rcon_sbox_pkg
// Shared AES constants for the key-schedule primitives: the byte type, the
// ten round constants and the forward S-box table.
// Ports: none (package).
// ---------------------------------------------------------------------------
package aes_rcon_sbox_pkg;

  typedef logic [7:0] aes_byte_t;

  // Round constants for AES-128 expansion steps 0..9.
  localparam aes_byte_t RCON_TABLE [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Forward S-box, indexed by the input byte. Element 0 is listed first.
  localparam logic [0:255][7:0] SBOX_TABLE = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Rcon for a 4-bit step index; indices past the last AES-128 round give 0.
  function automatic aes_byte_t rcon_of(input logic [3:0] idx);
    aes_byte_t result;
    result = 8'h00;
    if (idx <= 4'd9) begin
      result = RCON_TABLE[idx];
    end
    return result;
  endfunction

endpackage

// File: rtl/aes_rcon_sbox_if.sv
// ---------------------------------------------------------------------------
// aes_rcon_sbox_if
// Bundles the key-expander-facing signals of aes_rcon_sbox.
//   kld  : key-load strobe, restarts the Rcon sequence
//   out  : current round constant word (byte in [31:24])
//   sb_a : S-box lookup input byte
//   sb_b : S-box substitution result
// master : the key expander side (drives kld, sb_a)
// slave  : the aes_rcon_sbox side (drives out, sb_b)
// ---------------------------------------------------------------------------
interface aes_rcon_sbox_if;
  import aes_rcon_sbox_pkg::*;

  logic        kld;
  logic [31:0] out;
  aes_byte_t   sb_a;
  aes_byte_t   sb_b;

  modport master (
    output kld,
    output sb_a,
    input  out,
    input  sb_b
  );

  modport slave (
    input  kld,
    input  sb_a,
    output out,
    output sb_b
  );

endinterface

// File: rtl/aes_rcon_sbox_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational forward AES S-box. Instantiated once inside aes_rcon_sbox and
// four times directly by the key expander.
//   a : input byte
//   b : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox
  import aes_rcon_sbox_pkg::*;
(
  input  aes_byte_t a,
  output aes_byte_t b
);

  assign b = SBOX_TABLE[a];

endmodule

// File: rtl/aes_rcon_sbox.sv
// ---------------------------------------------------------------------------
// aes_rcon_sbox
// Round-constant generator for the AES-128 key schedule plus a pass-through
// forward S-box lookup. Holds no key state.
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : slave side of aes_rcon_sbox_if (kld, out, sb_a, sb_b)
// ---------------------------------------------------------------------------
module aes_rcon_sbox
  import aes_rcon_sbox_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  aes_rcon_sbox_if.slave bus
);

  logic [3:0] rcnt;
  logic [3:0] rcnt_next;
  aes_byte_t  rcon_byte;
  aes_byte_t  rcon_next_byte;

  // The counter wraps modulo 16, so the constant pattern repeats every
  // sixteen steps with six zero entries after 8'h36.
  always_comb begin
    rcnt_next      = rcnt + 4'd1;
    rcon_next_byte = rcon_of(rcnt_next);
  end

  // Reset and key load both restart at step 0; reset takes precedence.
  // Only the constant byte is stored, the low 24 bits are always zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rcnt      <= 4'd0;
      rcon_byte <= 8'h01;
    end else if (bus.kld) begin
      rcnt      <= 4'd0;
      rcon_byte <= 8'h01;
    end else begin
      rcnt      <= rcnt_next;
      rcon_byte <= rcon_next_byte;
    end
  end

  assign bus.out = {rcon_byte, 24'h00_0000};

  aes_sbox u_sbox (
    .a (bus.sb_a),
    .b (bus.sb_b)
  );

endmodule

// File: tb/tb_aes_rcon_sbox.sv
// ---------------------------------------------------------------------------
// tb_aes_rcon_sbox
// Directed bench for aes_rcon_sbox: Rcon sequencing, reload/reset priority,
// and the S-box against an arithmetic GF(2^8) model.
// ---------------------------------------------------------------------------
module tb_aes_rcon_sbox;

  logic clk;
  logic rst;
  int   compare_count;
  int   fail_count;
  logic [7:0] model_sbox [256];

  aes_rcon_sbox_if bus ();

  aes_rcon_sbox dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) doubling with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = x;
    bb = y;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse, then affine map.
  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, y[7:0]) == 8'h01) inv = y[7:0];
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  // Rcon for step k: repeated doubling from 01 for k < 10, zero otherwise.
  function automatic logic [7:0] rcon_model(input int k);
    logic [7:0] rc;
    int step;
    step = k % 16;
    rc = 8'h01;
    for (int i = 0; i < step; i++) rc = xtime(rc);
    if (step >= 10) rc = 8'h00;
    return rc;
  endfunction

  // Drive rst/kld away from the edge, take one rising edge, settle.
  task automatic applyStimulus(input logic rst_v, input logic kld_v);
    @(negedge clk);
    rst     = rst_v;
    bus.kld = kld_v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expected);
    compare_count++;
    assert (bus.out === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: out=%08h required=%08h", tag, bus.out, expected);
    end
  endtask

  task automatic checkSbox(input string tag, input logic [7:0] a_v, input logic [7:0] expected);
    bus.sb_a = a_v;
    #1;
    compare_count++;
    assert (bus.sb_b === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: sb_a=%02h sb_b=%02h required=%02h", tag, a_v, bus.sb_b, expected);
    end
  endtask

  initial begin
    compare_count = 0;
    fail_count    = 0;
    rst      = 1'b0;
    bus.kld  = 1'b0;
    bus.sb_a = 8'h00;
    for (int i = 0; i < 256; i++) model_sbox[i] = sbox_model(i[7:0]);

    $display("[TB] reset hold");
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("reset", 32'h0100_0000);

    $display("[TB] release from reset");
    applyStimulus(1'b1, 1'b0);
    checkOutput("post_reset_1", 32'h0200_0000);
    applyStimulus(1'b1, 1'b0);
    checkOutput("post_reset_2", 32'h0400_0000);
    applyStimulus(1'b1, 1'b0);
    checkOutput("post_reset_3", 32'h0800_0000);

    $display("[TB] full sequence with wrap");
    applyStimulus(1'b1, 1'b1);
    checkOutput("load", 32'h0100_0000);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("seq_k%0d", k), {rcon_model(k), 24'h0});
    end

    $display("[TB] mid-sequence reload");
    applyStimulus(1'b1, 1'b1);
    for (int k = 1; k <= 5; k++) applyStimulus(1'b1, 1'b0);
    checkOutput("reload_before", 32'h2000_0000);
    applyStimulus(1'b1, 1'b1);
    checkOutput("reload_hit", 32'h0100_0000);
    applyStimulus(1'b1, 1'b0);
    checkOutput("reload_next", 32'h0200_0000);

    $display("[TB] reset/load priority");
    applyStimulus(1'b0, 1'b1);
    checkOutput("rst_and_kld", 32'h0100_0000);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rst_and_kld_resume", 32'h0200_0000);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("mid_before_rst", 32'h1000_0000);
    applyStimulus(1'b0, 1'b0);
    checkOutput("mid_rst", 32'h0100_0000);
    applyStimulus(1'b1, 1'b0);
    checkOutput("mid_rst_resume", 32'h0200_0000);

    $display("[TB] S-box spot values");
    checkSbox("sbox_00", 8'h00, 8'h63);
    checkSbox("sbox_01", 8'h01, 8'h7c);
    checkSbox("sbox_53", 8'h53, 8'hed);
    checkSbox("sbox_80", 8'h80, 8'hcd);
    checkSbox("sbox_ff", 8'hff, 8'h16);
    checkSbox("sbox_10", 8'h10, 8'hca);

    $display("[TB] S-box sweep");
    for (int i = 0; i < 256; i++) begin
      checkSbox($sformatf("sbox_sweep_%02h", i), i[7:0], model_sbox[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
